// File: rtl/mult_div_ctrl.sv
// Multicycle signed MULT/DIV sequencer driving the HI/LO write port; WIDTH iterations then one DONE cycle.
// Optional macro DIVZERO_EXC_EN: divide-by-zero short-circuits to a one-cycle DZERO exception state.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             HI_write,
  output logic             LO_write,
  output logic [WIDTH-1:0] HI_in,
  output logic [WIDTH-1:0] LO_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DZERO = 3'd4;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       state;
  logic [CW-1:0]    count;
  // Shared datapath: MULT uses {acc_hi, acc_lo, booth_q} as the Booth register,
  // DIV uses acc_hi as partial remainder and acc_lo as dividend/quotient shifter.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             booth_q;
  logic [WIDTH-1:0] opnd;
  logic             neg_q, neg_r, b_zero;

  logic [WIDTH:0]   booth_sum, div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             nxt_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], booth_q})
      2'b01:   booth_sum = acc_hi + {opnd[WIDTH-1], opnd};
      2'b10:   booth_sum = acc_hi - {opnd[WIDTH-1], opnd};
      default: booth_sum = acc_hi;
    endcase
    div_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    div_ok   = !div_diff[WIDTH+1];
    if (state == S_MULT) begin
      nxt_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      nxt_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
      nxt_q  = acc_lo[0];
      res_hi = nxt_hi[WIDTH-1:0];
      res_lo = nxt_lo;
    end else begin
      nxt_hi = div_ok ? div_diff[WIDTH:0] : div_sh;
      nxt_lo = {acc_lo[WIDTH-2:0], div_ok};
      nxt_q  = 1'b0;
      res_hi = neg_r ? -nxt_hi[WIDTH-1:0] : nxt_hi[WIDTH-1:0];
      // A zero divisor yields an all-ones quotient regardless of dividend sign.
      res_lo = b_zero ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      booth_q <= 1'b0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      HI_in   <= '0;
      LO_in   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count   <= '0;
            booth_q <= 1'b0;
            acc_hi  <= '0;
            if (!op) begin
              acc_lo <= b_in;
              opnd   <= a_in;
              state  <= S_MULT;
            end
`ifdef DIVZERO_EXC_EN
            else if (b_in == '0) begin
              state <= S_DZERO;
            end
`endif
            else begin
              acc_lo <= a_mag;
              opnd   <= b_mag;
              neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r  <= a_in[WIDTH-1];
              b_zero <= (b_in == '0);
              state  <= S_DIV;
            end
          end
        end
        S_MULT, S_DIV: begin
          acc_hi  <= nxt_hi;
          acc_lo  <= nxt_lo;
          booth_q <= nxt_q;
          if (count == LAST) begin
            state <= S_DONE;
            HI_in <= res_hi;
            LO_in <= res_lo;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign HI_write = (state == S_DONE);
  assign LO_write = (state == S_DONE);
`ifdef DIVZERO_EXC_EN
  assign div_zero = (state == S_DZERO);
  assign done     = (state == S_DONE) || (state == S_DZERO);
`else
  assign div_zero = 1'b0;
  assign done     = (state == S_DONE);
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: cycle-level model plus directed vectors with literal results.
module tb_mult_div_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, div_zero, HI_write, LO_write;
  logic [W-1:0] HI_in, LO_in;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .HI_write(HI_write),
    .LO_write(LO_write), .HI_in(HI_in), .LO_in(LO_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_result(input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint p;
    logic [63:0] pv;
    int sa, sb;
    if (!o) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      hi = pv[63:32];
      lo = pv[31:0];
    end else if (b == '0) begin
      lo = '1;
      hi = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = '0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      lo = sa / sb;
      hi = sa % sb;
    end
  endtask

  // Model: cycles left until idle, and whether the current op is a DZERO exception.
  int           m_left = 0;
  bit           m_dz = 0;
  bit           m_ready = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_dz   = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left == 0) begin
      if (start) begin
`ifdef DIVZERO_EXC_EN
        if (op && b_in == '0) begin
          m_dz   = 1;
          m_left = 1;
        end else
`endif
        begin
          m_dz   = 0;
          m_left = W + 1;
          model_result(op, a_in, b_in, p_hi, p_lo);
        end
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
    m_ready = 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (m_ready) begin
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_left == 1));
        chk("hi_write", 64'(HI_write), 64'(m_left == 1 && !m_dz));
        chk("lo_write", 64'(LO_write), 64'(m_left == 1 && !m_dz));
        chk("div_zero", 64'(div_zero), 64'(m_left == 1 && m_dz));
        chk("hi_in", 64'(HI_in), 64'(m_hi));
        chk("lo_in", 64'(LO_in), 64'(m_lo));
      end
    end
  end

  task automatic issue(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic run(input string name, input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input bit pulse);
    int n;
    bit got;
    n   = 0;
    got = 0;
    issue(o, a, b);
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      if (pulse) begin
        if (n == 4 || n == 19) begin
          start = 1'b1;
          op    = ~o;
          a_in  = $urandom;
          b_in  = $urandom;
        end else if (n == 5 || n == 20) begin
          start = 1'b0;
        end
      end
    end
    chk({name, "_latency"}, 64'(n), 64'(W));
    chk({name, "_hi"}, 64'(HI_in), 64'(eh));
    chk({name, "_lo"}, 64'(LO_in), 64'(el));
    chk({name, "_write"}, 64'({HI_write, LO_write}), 64'(2'b11));
    @(negedge clk);
    chk({name, "_pulse"}, 64'({done, HI_write, busy}), 64'(3'b000));
  endtask

  initial begin
    int wr_seen;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({busy, done, div_zero, HI_write, LO_write}), 64'(5'b0));
    chk("reset_data", {HI_in, LO_in}, 64'h0);
    reset = 1'b0;

    run("mul_7_m3",    0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run("mul_min_min", 0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run("mul_m1_m1",   0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run("mul_100_200", 0, 32'd100,        32'd200,       32'h0000_0000, 32'h0000_4E20, 0);
    run("div_m7_2",    1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run("div_7_m2",    1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run("div_ovf",     1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run("div_100_7",   1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E, 0);

`ifdef DIVZERO_EXC_EN
    issue(1, 32'd5, 32'd0);
    chk("dz_flag", 64'({done, div_zero, busy}), 64'(3'b111));
    chk("dz_nowrite", 64'({HI_write, LO_write}), 64'(2'b00));
    chk("dz_hold", {HI_in, LO_in}, 64'h0000_0002_0000_000E);
    @(negedge clk);
    chk("dz_idle", 64'({busy, done, div_zero}), 64'(3'b000));
`else
    run("div_5_0",     1, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 0);
`endif

    run("mul_ignore",  0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);

    issue(1, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ctl", 64'({busy, done, HI_write, LO_write}), 64'(4'b0));
    chk("rst_mid_data", {HI_in, LO_in}, 64'h0);
    wr_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (HI_write || LO_write || busy) wr_seen++;
    end
    chk("rst_no_write", 64'(wr_seen), 64'(0));
    run("after_rst",   1, 32'd1000,       32'd3,         32'h0000_0001, 32'h0000_014D, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
